prog_mem_arbiter: RTL and testbench
===================================

Name: prog_mem_arbiter

Overview:
Shares the single synchronous read port of the program memory between two requesters: instruction fetch (IF, port 0) and a data-side/debug read port (DP, port 1). IF has fixed priority. A wait counter bounds DP starvation. The block tracks the one-cycle memory read latency and routes each returned word, with an error flag, back to the requester that owns it.

Parameters:
ADDR_WIDTH, 10, byte-address width presented to the memory (the memory indexes by addr>>2)
DATA_WIDTH, 32, instruction/data word width
MAX_WAIT, 4, consecutive cycles DP may be refused before it is forced to win arbitration (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch read request; held with if_addr stable until if_gnt
if_addr  input  ADDR_WIDTH  fetch byte address
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch response valid (one cycle after if_gnt)
if_rdata  output  DATA_WIDTH  fetch response word
if_err  output  1  fetch response is a misalignment error
dp_req  input  1  data-port read request; held with dp_addr stable until dp_gnt
dp_addr  input  ADDR_WIDTH  data-port byte address
dp_gnt  output  1  data-port request accepted this cycle
dp_rvalid  output  1  data-port response valid
dp_rdata  output  DATA_WIDTH  data-port response word
dp_err  output  1  data-port response is a misalignment error
mem_addr  output  ADDR_WIDTH  byte address driven to the program memory
mem_rdata  input  DATA_WIDTH  program memory registered read data (1-cycle latency)

Behaviour:
- Reset (rst_n low, async): if_gnt, dp_gnt = 0 while rst_n low. rvalid/rdata/err of both ports = 0. mem_addr = 0. Wait counter = 0. Response tag cleared. No rvalid is ever issued for a request granted before the reset.
- Arbitration (combinational, each cycle; at most one grant per cycle):
  - force = dp_req && (wait_cnt == MAX_WAIT).
  - force: dp_gnt=1, if_gnt=0.
  - else if_req: if_gnt=1.
  - else dp_req: dp_gnt=1.
- mem_addr = address of the granted requester in the grant cycle; 0 when no grant.
- Wait counter (registered, 4 bits): clears when dp_gnt or !dp_req; else increments when dp_req && !dp_gnt; saturates at MAX_WAIT.
- Response tracking (registered at posedge): resp_v <= any grant, resp_owner <= granted port, resp_err <= (granted addr[1:0] != 0).
- Response outputs, cycle N+1 after a grant in cycle N:
  - owner's rvalid = 1 for exactly one cycle.
  - rdata = mem_rdata when !resp_err, else 0; err = resp_err.
  - Non-owner port: rvalid/rdata/err = 0.
  - When resp_v = 0, all response outputs are 0.
- Misaligned request: still granted and still drives mem_addr (the memory read is harmless). The response carries err=1 and rdata=0.
- Pipelining: back-to-back grants are allowed every cycle. A grant in cycle N and a grant in cycle N+1 produce responses in N+1 and N+2. No buffering; requesters must always accept rvalid.
- Request withdrawn before grant: permitted; no response generated.
- Both requests in the same cycle with wait_cnt < MAX_WAIT: IF wins and the DP counter increments.

Test Plan:
- Reset mid-read: IF granted addr 0x010, rst_n pulled low before the next posedge -> no if_rvalid; all outputs 0 after release until a new request.
- Single fetch: if_req, if_addr=0x008, memory word[2]=0x00500093 -> if_gnt in cycle 0; if_rvalid=1, if_rdata=0x00500093, if_err=0 in cycle 1; dp outputs stay 0.
- Priority: if_req and dp_req both asserted for 1 cycle, then IF drops -> if_gnt in cycle 0, dp_gnt in cycle 1; responses in cycles 1 (IF) and 2 (DP).
- Starvation bound (MAX_WAIT=4): IF requests every cycle, dp_req held from cycle 0 with dp_addr=0x020 -> dp_gnt exactly in cycle 4 (if_gnt=0 that cycle); dp_rvalid in cycle 5 with word[8]; counter returns to 0.
- Misaligned: dp_addr=0x006 -> dp_gnt; next cycle dp_rvalid=1, dp_err=1, dp_rdata=0.
- Streaming: IF requests addrs 0x000,0x004,0x008 on consecutive cycles -> three consecutive if_rvalid cycles returning word[0], word[1], word[2] in order.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
// Arbitrates the program memory read port between instruction fetch (priority)
// and the data/debug port, and routes each one-cycle-late read word back to its owner.
module prog_mem_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [DATA_WIDTH-1:0] if_rdata,
   output logic                  if_err,
   input  logic                  dp_req,
   input  logic [ADDR_WIDTH-1:0] dp_addr,
   output logic                  dp_gnt,
   output logic                  dp_rvalid,
   output logic [DATA_WIDTH-1:0] dp_rdata,
   output logic                  dp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

   logic [3:0] wait_cnt;
   logic       force_dp;
   logic       any_gnt;
   logic       resp_v;
   logic       resp_owner;
   logic       resp_err;

   // Grants are held low during reset so nothing issued then can produce a response.
   always_comb begin
      if_gnt   = 1'b0;
      dp_gnt   = 1'b0;
      force_dp = dp_req && (wait_cnt == MAX_CNT);
      if (rst_n) begin
         if (force_dp) begin
            dp_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end else if (dp_req) begin
            dp_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_addr = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (dp_gnt) begin
         mem_addr = dp_addr;
      end
   end

   assign any_gnt = if_gnt | dp_gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         resp_v     <= 1'b0;
         resp_owner <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         if (dp_gnt || !dp_req) begin
            wait_cnt <= '0;
         end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 4'd1;
         end
         resp_v     <= any_gnt;
         resp_owner <= dp_gnt;
         resp_err   <= any_gnt && (mem_addr[1:0] != 2'b00);
      end
   end

   // A misaligned response returns zero data instead of the harmless memory read.
   assign if_rvalid = resp_v && !resp_owner;
   assign dp_rvalid = resp_v && resp_owner;
   assign if_err    = if_rvalid && resp_err;
   assign dp_err    = dp_rvalid && resp_err;
   assign if_rdata  = (if_rvalid && !resp_err) ? mem_rdata : '0;
   assign dp_rdata  = (dp_rvalid && !resp_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench for prog_mem_arbiter: grants are checked per cycle, responses are
// matched against a cycle-stamped scoreboard by an independent negedge monitor.
module tb_prog_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [9:0]  if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dp_req;
   logic [9:0]  dp_addr;
   logic        dp_gnt;
   logic        dp_rvalid;
   logic [31:0] dp_rdata;
   logic        dp_err;
   logic [9:0]  mem_addr;
   logic [31:0] mem_rdata;

   typedef struct {
      int          cyc;
      bit          port;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mem [256];
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;

   prog_mem_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .dp_req    (dp_req),
      .dp_addr   (dp_addr),
      .dp_gnt    (dp_gnt),
      .dp_rvalid (dp_rvalid),
      .dp_rdata  (dp_rdata),
      .dp_err    (dp_err),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 8'h00, 8'(i)};
      mem[2] = 32'h00500093;
      mem[8] = 32'hDEADBEEF;
   end

   always @(posedge clk) mem_rdata <= mem[mem_addr[9:2]];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of requests, checks the grant and memory address, and
   // queues the response expected on the following cycle.
   task automatic applyStimulus(input logic ir, input logic [9:0] ia, input logic dr,
                                input logic [9:0] da, input logic eig, input logic edg,
                                input logic [31:0] edata, input logic eerr,
                                input bit push, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      if_req  = ir;
      if_addr = ia;
      dp_req  = dr;
      dp_addr = da;
      #3;
      checkOutput({name, "_if_gnt"}, 64'(if_gnt), 64'(eig));
      checkOutput({name, "_dp_gnt"}, 64'(dp_gnt), 64'(edg));
      checkOutput({name, "_mem_addr"}, 64'(mem_addr), eig ? 64'(ia) : (edg ? 64'(da) : 64'd0));
      if (push && (eig || edg)) begin
         e.cyc  = cyc + 1;
         e.port = edg;
         e.data = edata;
         e.err  = eerr;
         sb.push_back(e);
      end
   endtask

   // Response monitor: owner gets the queued word, everything else must stay zero.
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("[TB] FAIL missing_resp: got no rvalid expected port %0d in cycle %0d", sb[0].port, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         if (!e.port) begin
            checkOutput("if_resp", {31'd0, if_rvalid, if_rdata, 1'b0, if_err}, {31'd0, 1'b1, e.data, 1'b0, e.err});
            checkOutput("dp_quiet", {dp_rvalid, dp_err, dp_rdata}, 64'd0);
         end else begin
            checkOutput("dp_resp", {31'd0, dp_rvalid, dp_rdata, 1'b0, dp_err}, {31'd0, 1'b1, e.data, 1'b0, e.err});
            checkOutput("if_quiet", {if_rvalid, if_err, if_rdata}, 64'd0);
         end
      end else begin
         checkOutput("idle_resp", {if_rvalid, dp_rvalid, if_err, dp_err, (|if_rdata), (|dp_rdata)}, 64'd0);
      end
   end

   initial begin
      rst_n   = 1'b0;
      if_req  = 1'b1;
      if_addr = 10'h008;
      dp_req  = 1'b1;
      dp_addr = 10'h020;
      #2;
      checkOutput("reset_gnt", {if_gnt, dp_gnt}, 64'd0);
      checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("reset_resp", {if_rvalid, dp_rvalid, if_err, dp_err, if_rdata, dp_rdata}, 64'd0);
      #20;
      if_req = 1'b0;
      dp_req = 1'b0;
      rst_n  = 1'b1;

      applyStimulus(1, 10'h008, 0, 10'h000, 1, 0, 32'h00500093, 0, 1, "single");
      applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "idle1");

      applyStimulus(1, 10'h00C, 1, 10'h014, 1, 0, 32'hC0DE0003, 0, 1, "prio_if");
      applyStimulus(0, 10'h000, 1, 10'h014, 0, 1, 32'hC0DE0005, 0, 1, "prio_dp");
      applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "idle2");

      applyStimulus(0, 10'h000, 1, 10'h006, 0, 1, 32'h0, 1, 1, "misalign");
      applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "idle3");

      applyStimulus(1, 10'h000, 0, 10'h000, 1, 0, 32'hC0DE0000, 0, 1, "stream0");
      applyStimulus(1, 10'h004, 0, 10'h000, 1, 0, 32'hC0DE0001, 0, 1, "stream1");
      applyStimulus(1, 10'h008, 0, 10'h000, 1, 0, 32'h00500093, 0, 1, "stream2");
      applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "idle4");

      // DP is refused four times, forced on the fifth, then the count restarts.
      applyStimulus(1, 10'h000, 1, 10'h020, 1, 0, 32'hC0DE0000, 0, 1, "starve0");
      applyStimulus(1, 10'h004, 1, 10'h020, 1, 0, 32'hC0DE0001, 0, 1, "starve1");
      applyStimulus(1, 10'h00C, 1, 10'h020, 1, 0, 32'hC0DE0003, 0, 1, "starve2");
      applyStimulus(1, 10'h010, 1, 10'h020, 1, 0, 32'hC0DE0004, 0, 1, "starve3");
      applyStimulus(1, 10'h014, 1, 10'h020, 0, 1, 32'hDEADBEEF, 0, 1, "starve4_force");
      applyStimulus(1, 10'h014, 1, 10'h024, 1, 0, 32'hC0DE0005, 0, 1, "starve5");
      applyStimulus(1, 10'h018, 1, 10'h024, 1, 0, 32'hC0DE0006, 0, 1, "starve6");
      applyStimulus(1, 10'h01C, 1, 10'h024, 1, 0, 32'hC0DE0007, 0, 1, "starve7");
      applyStimulus(1, 10'h000, 1, 10'h024, 1, 0, 32'hC0DE0000, 0, 1, "starve8");
      applyStimulus(1, 10'h004, 1, 10'h024, 0, 1, 32'hC0DE0009, 0, 1, "starve9_force");
      applyStimulus(1, 10'h004, 0, 10'h000, 1, 0, 32'hC0DE0001, 0, 1, "starve10");
      applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "idle5");

      // Reset lands between the grant and its response; no response may appear.
      applyStimulus(1, 10'h010, 0, 10'h000, 1, 0, 32'h0, 0, 0, "rst_grant");
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #4;
      checkOutput("rst_hold_gnt", {if_gnt, dp_gnt}, 64'd0);
      checkOutput("rst_hold_mem_addr", 64'(mem_addr), 64'd0);
      #3;
      rst_n  = 1'b1;
      if_req = 1'b0;
      @(posedge clk);
      #4;
      checkOutput("post_rst_outputs", {if_gnt, dp_gnt, if_rvalid, dp_rvalid, if_err, dp_err, if_rdata, dp_rdata}, 64'd0);
      checkOutput("post_rst_mem_addr", 64'(mem_addr), 64'd0);
      applyStimulus(1, 10'h004, 0, 10'h000, 1, 0, 32'hC0DE0001, 0, 1, "post_rst_fetch");

      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 10'h000, 0, 10'h000, 0, 0, 32'h0, 0, 1, "drain");
      end
      checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
